// File: rtl/reg_wr_arbiter.sv
// -----------------------------------------------------------------------------
// reg_wr_arbiter
//
// Purpose:
//   Arbitrates write requests from two masters onto a bank of NREG register
//   slices that share one data bus (reg_din) and have individual enables
//   (reg_en). Each grant runs IDLE -> WRITE -> ACK -> IDLE:
//     WRITE : reg_en is one-hot at the latched address for one cycle
//     ACK   : one-cycle ack pulse to the granted master
//   The winner's address and data are captured on the granting edge. Later
//   changes on the request inputs therefore cannot disturb a write in flight.
//
// Optional feature (compile-time macro ARB_ROUND_ROBIN_EN):
//   defined   : ties go to the master that was not granted last (round robin).
//   undefined : master 0 always wins ties and no last-grant state exists.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   req0/req1    write request, held high until the matching ack
//   addr0/addr1  target slice index (2 bits)
//   data0/data1  write data (DW bits)
//   ack0/ack1    one-cycle write-complete pulse
//   reg_en       one-hot per-slice write enable (NREG bits)
//   reg_din      shared write data to every slice
//   busy         high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module reg_wr_arbiter #(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic [1:0]      addr0,
  input  logic [DW-1:0]   data0,
  output logic            ack0,
  input  logic            req1,
  input  logic [1:0]      addr1,
  input  logic [DW-1:0]   data1,
  output logic            ack1,
  output logic [NREG-1:0] reg_en,
  output logic [DW-1:0]   reg_din,
  output logic            busy
);

  localparam int AW = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic [1:0]    r_state;
  logic          r_winner;   // 0 = master 0, 1 = master 1
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  logic          w_any_req;
  logic          w_grant;    // index of the master that wins this cycle
  logic [AW-1:0] w_grant_addr;
  logic [DW-1:0] w_grant_data;

  assign w_any_req = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
  // Index of the master granted most recently. Resets to 1 so that master 0
  // wins the first tie after reset.
  logic r_last_grant;

  always_comb begin
    w_grant = 1'b0;
    if (req0 && req1) begin
      w_grant = ~r_last_grant;
    end else if (req1) begin
      w_grant = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_last_grant <= w_grant;
    end
  end
`else
  // Fixed priority: master 1 only wins when master 0 is not asking.
  assign w_grant = req1 & ~req0;
`endif

  assign w_grant_addr = w_grant ? addr1 : addr0;
  assign w_grant_data = w_grant ? data1 : data0;

  // ---------------------------------------------------------------------------
  // State machine and capture of the granted transaction
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_winner <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state  <= ST_WRITE;
            r_winner <= w_grant;
            r_addr   <= w_grant_addr;
            r_data   <= w_grant_data;
          end
        end
        ST_WRITE: r_state <= ST_ACK;
        ST_ACK:   r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. All are decoded from registered state, so an asynchronous reset
  // drops reg_en/ack/busy in the same instant that it clears r_state.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_en
      assign reg_en[gi] = (r_state == ST_WRITE) && (r_addr == AW'(gi));
    end
  endgenerate

  // reg_din follows the captured data in every state, so slices see a stable
  // bus outside WRITE and the last written value is held there.
  assign reg_din = r_data;

  assign ack0 = (r_state == ST_ACK) && !r_winner;
  assign ack1 = (r_state == ST_ACK) &&  r_winner;
  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_reg_wr_arbiter.sv
module tb_reg_wr_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [1:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       ack0, ack1;
  logic [3:0] reg_en;
  logic [7:0] reg_din;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  reg_wr_arbiter #(.DW(8), .NREG(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .addr0   (addr0),
    .data0   (data0),
    .ack0    (ack0),
    .req1    (req1),
    .addr1   (addr1),
    .data1   (data1),
    .ack1    (ack1),
    .reg_en  (reg_en),
    .reg_din (reg_din),
    .busy    (busy)
  );

  // Register slices driven by the arbiter (reset value 0)
  logic [7:0] slice_q [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) slice_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) if (reg_en[i]) slice_q[i] <= reg_din;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Continuous invariants: one-hot enable, exclusive acks
  always @(negedge clk) begin
    if (!rst) begin
      check_val("en_onehot", 32'($countones(reg_en) <= 1), 32'd1);
      check_val("ack_excl", 32'(ack0 && ack1), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from IDLE, with requests already driven.
  // scramble: change the winner's addr/data during WRITE (must not matter).
  // drop:     winner deasserts req in the cycle after its ack.
  task automatic run_txn(input string tag, input int win, input logic [1:0] a,
                         input logic [7:0] d, input bit scramble, input bit drop);
    logic [3:0] exp_en;
    exp_en = 4'b0001 << a;
    tick();  // granting edge -> WRITE
    check_val({tag, "_en"},   32'(reg_en),  32'(exp_en));
    check_val({tag, "_din"},  32'(reg_din), 32'(d));
    check_val({tag, "_busyW"}, 32'(busy),   32'd1);
    check_val({tag, "_ackW"}, 32'({ack1, ack0}), 32'd0);
    if (scramble) begin
      if (win == 0) begin data0 = 8'h3C; addr0 = a + 2'd1; end
      else          begin data1 = 8'h3C; addr1 = a + 2'd1; end
    end
    tick();  // -> ACK, slice updated on this edge
    check_val({tag, "_ack0"}, 32'(ack0), 32'(win == 0));
    check_val({tag, "_ack1"}, 32'(ack1), 32'(win == 1));
    check_val({tag, "_enA"},  32'(reg_en), 32'd0);
    check_val({tag, "_busyA"}, 32'(busy), 32'd1);
    check_val({tag, "_slice"}, 32'(slice_q[a]), 32'(d));
    if (drop) begin
      if (win == 0) req0 = 1'b0;
      else          req1 = 1'b0;
    end
    tick();  // -> IDLE
    check_val({tag, "_busyI"}, 32'(busy), 32'd0);
    check_val({tag, "_dinI"},  32'(reg_din), 32'(d));
    check_val({tag, "_ackI"},  32'({ack1, ack0}), 32'd0);
    $display("TXN %s win=%0d addr=%0d data=%02h slice=%02h", tag, win, a, d, slice_q[a]);
  endtask

  initial begin
    int exp_win;
    rst   = 1'b1;
    req0  = 1'b0; addr0 = 2'd0; data0 = 8'h00;
    req1  = 1'b0; addr1 = 2'd0; data1 = 8'h00;
    #1;
    check_val("rst_en",   32'(reg_en),  32'd0);
    check_val("rst_din",  32'(reg_din), 32'd0);
    check_val("rst_ack",  32'({ack1, ack0}), 32'd0);
    check_val("rst_busy", 32'(busy),    32'd0);
    tick();
    tick();

    // Request raised while in reset: no grant until rst is low at an edge
    req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
    tick();
    check_val("rst_nogrant", 32'(busy), 32'd0);
    rst = 1'b0;

    // Single write to slice 2, data changed mid-write
    run_txn("single", 0, 2'd2, 8'hA5, 1'b1, 1'b1);

    // Lone requesters win regardless of history
    req1 = 1'b1; addr1 = 2'd1; data1 = 8'h5A;
    run_txn("solo1", 1, 2'd1, 8'h5A, 1'b0, 1'b1);
    req0 = 1'b1; addr0 = 2'd0; data0 = 8'h77;
    run_txn("solo0a", 0, 2'd0, 8'h77, 1'b0, 1'b1);
    req0 = 1'b1; addr0 = 2'd3; data0 = 8'hC3;
    run_txn("solo0b", 0, 2'd3, 8'hC3, 1'b0, 1'b1);

    // Reset in the middle of a write
    req0 = 1'b1; addr0 = 2'd1; data0 = 8'hEE;
    tick();
    check_val("mrst_enW", 32'(reg_en), 32'b0010);
    rst = 1'b1;
    #1;
    check_val("mrst_en",    32'(reg_en),  32'd0);
    check_val("mrst_busy",  32'(busy),    32'd0);
    check_val("mrst_din",   32'(reg_din), 32'd0);
    req0 = 1'b0;
    tick();
    check_val("mrst_ack",   32'({ack1, ack0}), 32'd0);
    check_val("mrst_slice", 32'(slice_q[1]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_val("mrst_idle",  32'(busy), 32'd0);
    check_val("mrst_ack2",  32'({ack1, ack0}), 32'd0);

    // Tie with both masters holding requests, fresh after reset
    req0 = 1'b1; addr0 = 2'd0; data0 = 8'h10;
    req1 = 1'b1; addr1 = 2'd1; data1 = 8'h20;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_win = t % 2;
`else
      exp_win = 0;
`endif
      run_txn($sformatf("tie%0d", t), exp_win,
              (exp_win == 1) ? 2'd1 : 2'd0,
              (exp_win == 1) ? 8'h20 : 8'h10, 1'b0, 1'b0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check_val("tie_idle", 32'(busy), 32'd0);

    // Back-to-back writes from master 1 holding its request
    req1 = 1'b1; addr1 = 2'd3; data1 = 8'h11;
    run_txn("b2b_a", 1, 2'd3, 8'h11, 1'b0, 1'b0);
    run_txn("b2b_b", 1, 2'd3, 8'h11, 1'b0, 1'b1);
    tick();
    check_val("b2b_done", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
